// File: rtl/cp0_core.sv
// cp0_core: MIPS-style coprocessor 0 register file with timer and exceptions.
// Holds Status/Cause/EPC/Count/Compare/BadVAddr plus PRId and Config constants.
module cp0_core #(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] PRID_VAL   = 32'h004C_0102
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [31:0]           wdata_i,
   input  logic [4:0]            raddr_i,
   output logic [31:0]           data_o,
   input  logic                  exc_valid_i,
   input  logic [4:0]            exc_code_i,
   input  logic [31:0]           exc_pc_i,
   input  logic                  exc_bd_i,
   input  logic [31:0]           exc_badva_i,
   input  logic                  eret_i,
   input  logic [HW_INT_NUM-1:0] hw_int_i,
   output logic [31:0]           status_o,
   output logic [31:0]           cause_o,
   output logic [31:0]           epc_o,
   output logic                  timer_int_o,
   output logic                  int_req_o
);

   localparam logic [3:0]  PRESC_MAX = 4'(COUNT_DIV - 1);
   localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

   logic [31:0] badva_q;
   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic [31:0] epc_q;
   logic [3:0]  presc_q;
   logic [7:0]  im_q;
   logic        exl_q;
   logic        ie_q;
   logic        bd_q;
   logic        ti_q;
   logic [5:0]  hw_q;
   logic [1:0]  sw_ip_q;
   logic [4:0]  exc_code_q;

   logic [5:0]  hw_ext;
   logic [7:0]  ip;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic        bad_addr_exc;

   assign wr_count     = we_i && (waddr_i == 5'd9);
   assign wr_compare   = we_i && (waddr_i == 5'd11);
   assign wr_status    = we_i && (waddr_i == 5'd12);
   assign wr_cause     = we_i && (waddr_i == 5'd13);
   assign wr_epc       = we_i && (waddr_i == 5'd14);
   assign bad_addr_exc = (exc_code_i == 5'd4) || (exc_code_i == 5'd5);

   // Zero-extend the hardware interrupt lines to the full six IP slots.
   always_comb begin
      hw_ext = '0;
      hw_ext[HW_INT_NUM-1:0] = hw_int_i;
   end

   assign ip = {hw_q[5] | ti_q, hw_q[4:0], sw_ip_q};

   assign status_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_o  = {bd_q, ti_q, 14'd0, ip, 1'b0, exc_code_q, 2'b00};
   assign epc_o    = epc_q;

   assign timer_int_o = ti_q;
   assign int_req_o   = ie_q & ~exl_q & |(ip & im_q);

   // Read port: combinational decode of raddr_i, forced to zero in reset.
   always_comb begin
      data_o = '0;
      if (!rst) begin
         case (raddr_i)
            5'd8:    data_o = badva_q;
            5'd9:    data_o = count_q;
            5'd11:   data_o = compare_q;
            5'd12:   data_o = status_o;
            5'd13:   data_o = cause_o;
            5'd14:   data_o = epc_q;
            5'd15:   data_o = PRID_VAL;
            5'd16:   data_o = CONFIG_VAL;
            default: data_o = '0;
         endcase
      end
   end

   // Count advances once per prescaler wrap; an mtc0 reloads it.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         count_q <= '0;
      end else if (wr_count) begin
         presc_q <= '0;
         count_q <= wdata_i;
      end else if (presc_q == PRESC_MAX) begin
         presc_q <= '0;
         count_q <= count_q + 32'd1;
      end else begin
         presc_q <= presc_q + 4'd1;
      end
   end

   // Compare register and sticky timer interrupt, cleared by Compare write.
   always_ff @(posedge clk) begin
      if (rst) begin
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else if (wr_compare) begin
         compare_q <= wdata_i;
         ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
         ti_q      <= 1'b1;
      end
   end

   // Status: exception sets EXL, eret clears it, both beat an mtc0.
   always_ff @(posedge clk) begin
      if (rst) begin
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
      end else begin
         if (wr_status) begin
            im_q  <= wdata_i[15:8];
            exl_q <= wdata_i[1];
            ie_q  <= wdata_i[0];
         end
         if (exc_valid_i)
            exl_q <= 1'b1;
         else if (eret_i)
            exl_q <= 1'b0;
      end
   end

   // Cause: sampled hw lines, software IP, and exception-owned fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         hw_q       <= '0;
         sw_ip_q    <= '0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
      end else begin
         hw_q <= hw_ext;
         if (wr_cause)
            sw_ip_q <= wdata_i[9:8];
         if (exc_valid_i) begin
            exc_code_q <= exc_code_i;
            if (!exl_q)
               bd_q <= exc_bd_i;
         end
      end
   end

   // EPC captured only on first-level exceptions; BadVAddr on AdEL/AdES.
   always_ff @(posedge clk) begin
      if (rst) begin
         epc_q   <= '0;
         badva_q <= '0;
      end else begin
         if (exc_valid_i && !exl_q)
            epc_q <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
         else if (wr_epc)
            epc_q <= wdata_i;
         if (exc_valid_i && bad_addr_exc)
            badva_q <= exc_badva_i;
      end
   end

endmodule

// File: tb/tb_cp0_core.sv
// tb_cp0_core: directed checks for cp0_core timer, interrupts and exceptions.
// A second instance with COUNT_DIV=1 shares all inputs for the wrap case.
module tb_cp0_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  raddr = '0;
   logic        exc_valid = 1'b0;
   logic [4:0]  exc_code = '0;
   logic [31:0] exc_pc = '0;
   logic        exc_bd = 1'b0;
   logic [31:0] exc_badva = '0;
   logic        eret = 1'b0;
   logic [5:0]  hw_int = '0;

   logic [31:0] data, status, cause, epc;
   logic        ti, irq;
   logic [31:0] data1, status1, cause1, epc1;
   logic        ti1, irq1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp0_core dut (
      .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .data_o(data), .exc_valid_i(exc_valid),
      .exc_code_i(exc_code), .exc_pc_i(exc_pc), .exc_bd_i(exc_bd),
      .exc_badva_i(exc_badva), .eret_i(eret), .hw_int_i(hw_int),
      .status_o(status), .cause_o(cause), .epc_o(epc),
      .timer_int_o(ti), .int_req_o(irq)
   );

   cp0_core #(.COUNT_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .data_o(data1), .exc_valid_i(exc_valid),
      .exc_code_i(exc_code), .exc_pc_i(exc_pc), .exc_bd_i(exc_bd),
      .exc_badva_i(exc_badva), .eret_i(eret), .hw_int_i(hw_int),
      .status_o(status1), .cause_o(cause1), .epc_o(epc1),
      .timer_int_o(ti1), .int_req_o(irq1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0;
      exc_valid = 1'b0;
      eret = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a);
      raddr = a;
      #1;
   endtask

   initial begin
      int n;
      // reset
      tick();
      rd(5'd12);
      chk("rd_in_rst", data, 32'h0);
      tick();
      rst = 1'b0;
      chk("rst_status", status, 32'h0040_0000);
      chk("rst_cause", cause, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_ti", 32'(ti), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      rd(5'd16);
      chk("rst_config", data, 32'h0000_8000);
      rd(5'd15);
      chk("prid", data, 32'h004C_0102);
      rd(5'd9);
      chk("rst_count", data, 32'h0);

      // Compare=3, timer fires after six cycles
      we = 1'b1; waddr = 5'd11; wdata = 32'd3;
      tick();
      idle();
      n = 0;
      while (!ti && n < 40) begin
         tick();
         n++;
      end
      chk("ti_set", 32'(ti), 32'h1);
      chk("ti_lat", 32'(n), 32'd6);
      rd(5'd9);
      chk("cnt_at_ti", data, 32'd3);
      chk("cause_ti", {30'd0, cause[30], cause[15]}, 32'h3);

      // Compare=10 clears TI
      we = 1'b1; waddr = 5'd11; wdata = 32'd10;
      tick();
      idle();
      chk("ti_clr", 32'(ti), 32'h0);
      chk("ip7_clr", 32'(cause[15]), 32'h0);

      // Status IE + IM7, interrupt once TI returns
      we = 1'b1; waddr = 5'd12; wdata = 32'h0000_8001;
      tick();
      idle();
      chk("status_w", status, 32'h0040_8001);
      chk("irq_noti", 32'(irq), 32'h0);
      n = 0;
      while (!ti && n < 40) begin
         tick();
         n++;
      end
      chk("ti_again", 32'(ti), 32'h1);
      chk("irq_on", 32'(irq), 32'h1);

      // exception masks, eret unmasks
      exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h100; exc_bd = 1'b0;
      tick();
      idle();
      chk("exl_set", 32'(status[1]), 32'h1);
      chk("irq_exl", 32'(irq), 32'h0);
      chk("epc_nbd", epc, 32'h100);
      eret = 1'b1;
      tick();
      idle();
      chk("exl_eret", 32'(status[1]), 32'h0);
      chk("irq_back", 32'(irq), 32'h1);

      // AdEL in delay slot
      exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_0100;
      exc_bd = 1'b1; exc_badva = 32'h3;
      tick();
      idle();
      chk("epc_bd", epc, 32'hBFC0_00FC);
      chk("bd_set", 32'(cause[31]), 32'h1);
      chk("code4", 32'(cause[6:2]), 32'd4);
      rd(5'd8);
      chk("badva", data, 32'h3);
      chk("exl_ade", 32'(status[1]), 32'h1);

      // nested exception plus eret in same cycle
      exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_0010;
      exc_bd = 1'b0; exc_badva = 32'h55; eret = 1'b1;
      tick();
      idle();
      chk("epc_keep", epc, 32'hBFC0_00FC);
      chk("code8", 32'(cause[6:2]), 32'd8);
      chk("bd_keep", 32'(cause[31]), 32'h1);
      chk("exl_keep", 32'(status[1]), 32'h1);
      rd(5'd8);
      chk("badva_keep", data, 32'h3);

      // mtc0 EPC while EXL=1 takes effect
      we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234;
      tick();
      idle();
      chk("epc_mtc0", epc, 32'h0000_1234);

      // eret, then mtc0 Status=0 racing an exception
      eret = 1'b1;
      tick();
      idle();
      we = 1'b1; waddr = 5'd12; wdata = 32'h0;
      exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h200; exc_bd = 1'b0;
      tick();
      idle();
      chk("st_race", status, 32'h0040_0002);
      chk("epc_race", epc, 32'h200);
      chk("irq_race", 32'(irq), 32'h0);

      // hardware line 0 and software IP
      hw_int = 6'h01;
      tick();
      chk("ip2_hw", 32'(cause[10]), 32'h1);
      we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF;
      tick();
      idle();
      chk("cause_w", cause, 32'h4000_8700);
      rd(5'd3);
      chk("unimpl", data, 32'h0);

      // Count wrap on both prescaler settings
      we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
      tick();
      idle();
      rd(5'd9);
      chk("cnt_ld", data1, 32'hFFFF_FFFF);
      tick();
      chk("cnt_wrap1", data1, 32'h0);
      chk("cnt_hold2", data, 32'hFFFF_FFFF);
      tick();
      chk("cnt_wrap2", data, 32'h0);

      // reset mid-run beats everything
      rst = 1'b1;
      we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
      exc_valid = 1'b1; exc_code = 5'd4; exc_badva = 32'hDEAD;
      eret = 1'b1;
      #1;
      chk("rd_rst_mid", data, 32'h0);
      tick();
      rst = 1'b0;
      idle();
      #1;
      chk("mr_status", status, 32'h0040_0000);
      chk("mr_cause", cause, 32'h0);
      chk("mr_epc", epc, 32'h0);
      chk("mr_ti", 32'(ti), 32'h0);
      chk("mr_irq", 32'(irq), 32'h0);
      rd(5'd9);
      chk("mr_count", data, 32'h0);
      rd(5'd11);
      chk("mr_compare", data, 32'h0);
      rd(5'd8);
      chk("mr_badva", data, 32'h0);
      rd(5'd16);
      chk("mr_config", data, 32'h0000_8000);
      chk("mr1_status", status1, 32'h0040_0000);
      chk("mr1_cause", cause1, 32'h0);
      chk("mr1_epc", epc1, 32'h0);
      chk("mr1_ti_irq", {30'd0, ti1, irq1}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
